// File: rtl/udma_filter_pkg.sv
// Mode encodings and operand-routing decode for the uDMA filter arithmetic unit.
package udma_filter_pkg;

   localparam logic [3:0] MODE_AXB       = 4'd0;   // A*B
   localparam logic [3:0] MODE_AXBPREG   = 4'd1;   // A*B + reg0
   localparam logic [3:0] MODE_AXBACC    = 4'd2;   // acc += A*B
   localparam logic [3:0] MODE_AXREG     = 4'd3;   // A*reg1
   localparam logic [3:0] MODE_AXREGPB   = 4'd4;   // A*reg1 + B
   localparam logic [3:0] MODE_AXREGMB   = 4'd5;   // A*reg1 - B
   localparam logic [3:0] MODE_AXAACC    = 4'd6;   // acc += A*A
   localparam logic [3:0] MODE_AXA       = 4'd7;   // A*A
   localparam logic [3:0] MODE_AXAPREG   = 4'd8;   // A*A + reg0
   localparam logic [3:0] MODE_AXAPB     = 4'd9;   // A*A + B
   localparam logic [3:0] MODE_AXAMB     = 4'd10;  // A*A - B
   localparam logic [3:0] MODE_AXREGPREG = 4'd11;  // A*reg1 + reg0
   localparam logic [3:0] MODE_AXREGACC  = 4'd12;  // acc += A*reg1
   localparam logic [3:0] MODE_APB       = 4'd13;  // A + B
   localparam logic [3:0] MODE_AMB       = 4'd14;  // A - B
   localparam logic [3:0] MODE_APREG     = 4'd15;  // A + reg0

   typedef enum logic [1:0] {MUL_B, MUL_A, MUL_REG1, MUL_ONE} mul_sel_e;
   typedef enum logic [1:0] {SUM_B, SUM_REG0, SUM_ACC, SUM_ZERO} sum_sel_e;

   typedef struct packed {
      logic     en_opb;
      mul_sel_e mul_sel;
      sum_sel_e sum_sel;
      logic     sum_inv;
      logic     acc;
   } filter_dec_t;

   function automatic filter_dec_t filter_decode(input logic [3:0] mode);
      filter_dec_t d;
      d = '{en_opb: 1'b0, mul_sel: MUL_ONE, sum_sel: SUM_REG0, sum_inv: 1'b0, acc: 1'b0};
      case (mode)
         MODE_AXB:       begin d.en_opb = 1'b1; d.mul_sel = MUL_B; d.sum_sel = SUM_ZERO; end
         MODE_AXBPREG:   begin d.en_opb = 1'b1; d.mul_sel = MUL_B; d.sum_sel = SUM_REG0; end
         MODE_AXBACC:    begin d.en_opb = 1'b1; d.mul_sel = MUL_B; d.sum_sel = SUM_ACC; d.acc = 1'b1; end
         MODE_AXREG:     begin d.mul_sel = MUL_REG1; d.sum_sel = SUM_ZERO; end
         MODE_AXREGPB:   begin d.en_opb = 1'b1; d.mul_sel = MUL_REG1; d.sum_sel = SUM_B; end
         MODE_AXREGMB:   begin d.en_opb = 1'b1; d.mul_sel = MUL_REG1; d.sum_sel = SUM_B; d.sum_inv = 1'b1; end
         MODE_AXAACC:    begin d.mul_sel = MUL_A; d.sum_sel = SUM_ACC; d.acc = 1'b1; end
         MODE_AXA:       begin d.mul_sel = MUL_A; d.sum_sel = SUM_ZERO; end
         MODE_AXAPREG:   begin d.mul_sel = MUL_A; d.sum_sel = SUM_REG0; end
         MODE_AXAPB:     begin d.en_opb = 1'b1; d.mul_sel = MUL_A; d.sum_sel = SUM_B; end
         MODE_AXAMB:     begin d.en_opb = 1'b1; d.mul_sel = MUL_A; d.sum_sel = SUM_B; d.sum_inv = 1'b1; end
         MODE_AXREGPREG: begin d.mul_sel = MUL_REG1; d.sum_sel = SUM_REG0; end
         MODE_AXREGACC:  begin d.mul_sel = MUL_REG1; d.sum_sel = SUM_ACC; d.acc = 1'b1; end
         MODE_APB:       begin d.en_opb = 1'b1; d.mul_sel = MUL_ONE; d.sum_sel = SUM_B; end
         MODE_AMB:       begin d.en_opb = 1'b1; d.mul_sel = MUL_ONE; d.sum_sel = SUM_B; d.sum_inv = 1'b1; end
         default:        begin d.mul_sel = MUL_ONE; d.sum_sel = SUM_REG0; end
      endcase
      return d;
   endfunction

endpackage

// File: rtl/udma_filter_shsat.sv
// Combinational output conditioning: optional round-half-up, right shift, then
// saturation (or truncation) down to DATA_WIDTH.
module udma_filter_shsat #(
   parameter int DATA_WIDTH = 32,
   parameter int ACC_WIDTH  = 40,
   parameter int SHIFT_W    = 6
) (
   input  logic [ACC_WIDTH-1:0]  value,
   input  logic                  use_signed,
   input  logic                  rnd_en,
   input  logic                  sat_en,
   input  logic [SHIFT_W-1:0]    shift,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  sat_hit
);

   // One guard bit so the rounding increment can never wrap.
   localparam int EW = ACC_WIDTH + 1;

   logic [EW-1:0] ext_v;
   logic [EW-1:0] rnd_v;
   logic [EW-1:0] sum_v;
   logic [EW-1:0] shifted;
   logic          hi_ovf;
   logic          lo_ovf;

   always_comb begin
      ext_v = {use_signed & value[ACC_WIDTH-1], value};
      rnd_v = '0;
      if (rnd_en && shift != '0)
         rnd_v = EW'(1) << (shift - SHIFT_W'(1));
      sum_v = ext_v + rnd_v;
      if (use_signed)
         shifted = EW'($signed(sum_v) >>> shift);
      else
         shifted = sum_v >> shift;

      hi_ovf = 1'b0;
      lo_ovf = 1'b0;
      if (use_signed) begin
         hi_ovf = ~shifted[EW-1] & (|shifted[EW-2:DATA_WIDTH-1]);
         lo_ovf = shifted[EW-1] & ~(&shifted[EW-2:DATA_WIDTH-1]);
      end else begin
         hi_ovf = |shifted[EW-1:DATA_WIDTH];
      end

      data    = shifted[DATA_WIDTH-1:0];
      sat_hit = 1'b0;
      if (sat_en && hi_ovf) begin
         data    = use_signed ? {1'b0, {(DATA_WIDTH-1){1'b1}}} : {DATA_WIDTH{1'b1}};
         sat_hit = 1'b1;
      end else if (sat_en && lo_ovf) begin
         data    = {1'b1, {(DATA_WIDTH-1){1'b0}}};
         sat_hit = 1'b1;
      end
   end

endmodule

// File: rtl/udma_filter_au_pipe.sv
// uDMA filter arithmetic unit: 3-stage back-pressurable multiply/add/accumulate
// pipeline between the operand streamers and the output streamer.
module udma_filter_au_pipe
   import udma_filter_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ACC_WIDTH  = 40,
   parameter int SHIFT_W    = 6
) (
   input  logic                  clk_i,
   input  logic                  resetn_i,
   input  logic                  cfg_use_signed_i,
   input  logic                  cfg_bypass_i,
   input  logic [3:0]            cfg_mode_i,
   input  logic [SHIFT_W-1:0]    cfg_shift_i,
   input  logic                  cfg_round_i,
   input  logic                  cfg_sat_i,
   input  logic [DATA_WIDTH-1:0] cfg_reg0_i,
   input  logic [DATA_WIDTH-1:0] cfg_reg1_i,
   input  logic                  cmd_start_i,
   input  logic [DATA_WIDTH-1:0] operanda_data_i,
   input  logic [1:0]            operanda_datasize_i,
   input  logic                  operanda_valid_i,
   input  logic                  operanda_sof_i,
   input  logic                  operanda_eof_i,
   output logic                  operanda_ready_o,
   input  logic [DATA_WIDTH-1:0] operandb_data_i,
   input  logic [1:0]            operandb_datasize_i,
   input  logic                  operandb_valid_i,
   output logic                  operandb_ready_o,
   output logic [DATA_WIDTH-1:0] output_data_o,
   output logic [1:0]            output_datasize_o,
   output logic                  output_valid_o,
   input  logic                  output_ready_i,
   output logic                  status_sat_o
);

   function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] d,
                                                    input logic [1:0] size, input logic sgn);
      case (size)
         2'd0:    return {{(DATA_WIDTH-8){sgn & d[7]}}, d[7:0]};
         2'd1:    return {{(DATA_WIDTH-16){sgn & d[15]}}, d[15:0]};
         default: return d;
      endcase
   endfunction

   function automatic logic [ACC_WIDTH-1:0] to_acc(input logic [DATA_WIDTH-1:0] d, input logic sgn);
      return {{(ACC_WIDTH-DATA_WIDTH){sgn & d[DATA_WIDTH-1]}}, d};
   endfunction

   filter_dec_t           dec;
   logic                  need_b, acc_mode, accept;
   logic                  s0_adv, s1_adv, s2_adv;
   logic                  s0_valid, s0_sof, s0_eof;
   logic [1:0]            s0_size, s1_size;
   logic [DATA_WIDTH-1:0] s0_a, s0_b;
   logic                  s1_valid;
   logic [ACC_WIDTH-1:0]  s1_prod, acc_q;
   logic [ACC_WIDTH-1:0]  a_x, mul_op, sum_op, prod;
   logic [DATA_WIDTH-1:0] sh_data;
   logic                  sh_sat;

   always_comb dec = filter_decode(cfg_mode_i);
   assign need_b   = dec.en_opb & ~cfg_bypass_i;
   assign acc_mode = dec.acc & ~cfg_bypass_i;

   // Handshake: a beat moves on a stream in any cycle where valid and ready are
   // both high. A and B move together; B ready is only raised when the mode
   // consumes B, and neither ready depends on ready being observed by the source.
   assign s2_adv = ~output_valid_o | output_ready_i;
   assign s1_adv = ~s1_valid | s2_adv;
   assign s0_adv = ~s0_valid | s1_adv;
   assign accept = s0_adv & operanda_valid_i & (~need_b | operandb_valid_i) & ~cmd_start_i;
   assign operanda_ready_o = accept;
   assign operandb_ready_o = accept & need_b;

   always_comb begin
      a_x = to_acc(s0_a, cfg_use_signed_i);
      case (dec.mul_sel)
         MUL_B:    mul_op = to_acc(s0_b, cfg_use_signed_i);
         MUL_A:    mul_op = a_x;
         MUL_REG1: mul_op = to_acc(cfg_reg1_i, cfg_use_signed_i);
         default:  mul_op = ACC_WIDTH'(1);
      endcase
      case (dec.sum_sel)
         SUM_B:    sum_op = to_acc(s0_b, cfg_use_signed_i);
         SUM_REG0: sum_op = to_acc(cfg_reg0_i, cfg_use_signed_i);
         SUM_ACC:  sum_op = s0_sof ? '0 : acc_q;
         default:  sum_op = '0;
      endcase
      if (cfg_bypass_i)
         prod = a_x;
      else
         prod = a_x * mul_op + (dec.sum_inv ? -sum_op : sum_op);
   end

   udma_filter_shsat #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .SHIFT_W    (SHIFT_W)
   ) u_shsat (
      .value      (s1_prod),
      .use_signed (cfg_use_signed_i),
      .rnd_en     (cfg_round_i),
      .sat_en     (cfg_sat_i),
      .shift      (cfg_shift_i),
      .data       (sh_data),
      .sat_hit    (sh_sat)
   );

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         s0_valid          <= 1'b0;
         s0_sof            <= 1'b0;
         s0_eof            <= 1'b0;
         s0_size           <= '0;
         s0_a              <= '0;
         s0_b              <= '0;
         s1_valid          <= 1'b0;
         s1_size           <= '0;
         s1_prod           <= '0;
         acc_q             <= '0;
         output_valid_o    <= 1'b0;
         output_data_o     <= '0;
         output_datasize_o <= '0;
         status_sat_o      <= 1'b0;
      end else if (cmd_start_i) begin
         s0_valid       <= 1'b0;
         s1_valid       <= 1'b0;
         output_valid_o <= 1'b0;
         acc_q          <= '0;
         status_sat_o   <= 1'b0;
      end else begin
         if (s0_adv) begin
            s0_valid <= accept;
            if (accept) begin
               s0_a    <= extend(operanda_data_i, operanda_datasize_i, cfg_use_signed_i);
               s0_b    <= extend(operandb_data_i, operandb_datasize_i, cfg_use_signed_i);
               s0_sof  <= operanda_sof_i;
               s0_eof  <= operanda_eof_i;
               s0_size <= operanda_datasize_i;
            end
         end
         // Accumulating beats fold into acc_q; only the frame's last beat continues.
         if (s1_adv) begin
            s1_valid <= s0_valid & (~acc_mode | s0_eof);
            if (s0_valid) begin
               s1_prod <= prod;
               s1_size <= s0_size;
               if (acc_mode)
                  acc_q <= prod;
            end
         end
         if (s2_adv) begin
            output_valid_o <= s1_valid;
            if (s1_valid) begin
               output_data_o     <= sh_data;
               output_datasize_o <= s1_size;
               if (sh_sat)
                  status_sat_o <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_udma_filter_au_pipe.sv
// Bench for udma_filter_au_pipe: directed scenarios plus randomized blocks,
// checked against an arithmetic reference model and an expected-output queue.
module tb_udma_filter_au_pipe;

   logic        clk_i = 1'b0;
   logic        resetn_i = 1'b0;
   logic        cfg_use_signed_i = 1'b0;
   logic        cfg_bypass_i = 1'b0;
   logic [3:0]  cfg_mode_i = 4'd0;
   logic [5:0]  cfg_shift_i = 6'd0;
   logic        cfg_round_i = 1'b0;
   logic        cfg_sat_i = 1'b0;
   logic [31:0] cfg_reg0_i = 32'd0;
   logic [31:0] cfg_reg1_i = 32'd0;
   logic        cmd_start_i = 1'b0;
   logic [31:0] operanda_data_i = 32'd0;
   logic [1:0]  operanda_datasize_i = 2'd2;
   logic        operanda_valid_i = 1'b0;
   logic        operanda_sof_i = 1'b0;
   logic        operanda_eof_i = 1'b0;
   logic        operanda_ready_o;
   logic [31:0] operandb_data_i = 32'd0;
   logic [1:0]  operandb_datasize_i = 2'd2;
   logic        operandb_valid_i = 1'b0;
   logic        operandb_ready_o;
   logic [31:0] output_data_o;
   logic [1:0]  output_datasize_o;
   logic        output_valid_o;
   logic        output_ready_i;
   logic        status_sat_o;

   logic        man_rdy = 1'b1;
   logic        rnd_rdy = 1'b1;
   logic        rand_en = 1'b0;
   assign output_ready_i = rand_en ? rnd_rdy : man_rdy;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          acc_cyc = 0;
   int          last_out_cyc = 0;
   int          out_count = 0;
   logic [31:0] last_out_data = '0;
   logic [1:0]  last_out_size = '0;
   logic        saw_stall = 1'b0;
   longint      model_acc = 0;
   logic        model_sat = 1'b0;
   logic [33:0] exp_q[$];

   udma_filter_au_pipe dut (
      .clk_i               (clk_i),
      .resetn_i            (resetn_i),
      .cfg_use_signed_i    (cfg_use_signed_i),
      .cfg_bypass_i        (cfg_bypass_i),
      .cfg_mode_i          (cfg_mode_i),
      .cfg_shift_i         (cfg_shift_i),
      .cfg_round_i         (cfg_round_i),
      .cfg_sat_i           (cfg_sat_i),
      .cfg_reg0_i          (cfg_reg0_i),
      .cfg_reg1_i          (cfg_reg1_i),
      .cmd_start_i         (cmd_start_i),
      .operanda_data_i     (operanda_data_i),
      .operanda_datasize_i (operanda_datasize_i),
      .operanda_valid_i    (operanda_valid_i),
      .operanda_sof_i      (operanda_sof_i),
      .operanda_eof_i      (operanda_eof_i),
      .operanda_ready_o    (operanda_ready_o),
      .operandb_data_i     (operandb_data_i),
      .operandb_datasize_i (operandb_datasize_i),
      .operandb_valid_i    (operandb_valid_i),
      .operandb_ready_o    (operandb_ready_o),
      .output_data_o       (output_data_o),
      .output_datasize_o   (output_datasize_o),
      .output_valid_o      (output_valid_o),
      .output_ready_i      (output_ready_i),
      .status_sat_o        (status_sat_o)
   );

   // Clock and reset
   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   initial begin
      forever begin
         @(posedge clk_i);
         #1 rnd_rdy = 1'($urandom_range(0, 1));
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model
   function automatic longint ext(input logic [31:0] d, input logic [1:0] s, input logic sgn);
      longint v;
      case (s)
         2'd0:    if (sgn) v = longint'(byte'(d[7:0]));     else v = longint'(d[7:0]);
         2'd1:    if (sgn) v = longint'(shortint'(d[15:0])); else v = longint'(d[15:0]);
         default: if (sgn) v = longint'(int'(d));            else v = longint'(d);
      endcase
      return v;
   endfunction

   task automatic model_beat(input logic [31:0] a_raw, input logic [1:0] as, input logic [31:0] b_raw,
                             input logic [1:0] bs, input logic sof, input logic eof);
      longint a, b, r0, r1, r, hi, lo;
      logic   sgn;
      logic   emit;
      int     sh;
      sgn  = cfg_use_signed_i;
      sh   = int'(cfg_shift_i);
      emit = 1'b1;
      a  = ext(a_raw, as, sgn);
      b  = ext(b_raw, bs, sgn);
      r0 = ext(cfg_reg0_i, 2'd2, sgn);
      r1 = ext(cfg_reg1_i, 2'd2, sgn);
      if (cfg_bypass_i) r = a;
      else begin
         case (cfg_mode_i)
            4'd0:  r = a * b;
            4'd1:  r = a * b + r0;
            4'd2:  begin model_acc = (sof ? 0 : model_acc) + a * b;  r = model_acc; emit = eof; end
            4'd3:  r = a * r1;
            4'd4:  r = a * r1 + b;
            4'd5:  r = a * r1 - b;
            4'd6:  begin model_acc = (sof ? 0 : model_acc) + a * a;  r = model_acc; emit = eof; end
            4'd7:  r = a * a;
            4'd8:  r = a * a + r0;
            4'd9:  r = a * a + b;
            4'd10: r = a * a - b;
            4'd11: r = a * r1 + r0;
            4'd12: begin model_acc = (sof ? 0 : model_acc) + a * r1; r = model_acc; emit = eof; end
            4'd13: r = a + b;
            4'd14: r = a - b;
            default: r = a + r0;
         endcase
      end
      r = r & ((longint'(1) << 40) - 1);
      if (sgn && r[39]) r = r - (longint'(1) << 40);
      if (cfg_round_i && sh > 0) r = r + (longint'(1) << (sh - 1));
      r = r >>> sh;
      if (cfg_sat_i) begin
         hi = sgn ? (longint'(1) << 31) - 1 : (longint'(1) << 32) - 1;
         lo = sgn ? -(longint'(1) << 31) : 0;
         if (r > hi) begin r = hi; model_sat = 1'b1; end
         else if (r < lo) begin r = lo; model_sat = 1'b1; end
      end
      if (emit) exp_q.push_back({as, r[31:0]});
   endtask

   // Driver tasks (entered just after a rising edge)
   task automatic send(input logic [31:0] a, input logic [1:0] as, input logic [31:0] b,
                       input logic [1:0] bs, input logic sof, input logic eof);
      int          waited;
      logic [15:0] nb_mask;
      waited  = 0;
      nb_mask = 16'h6637;
      operanda_data_i = a;  operanda_datasize_i = as;
      operandb_data_i = b;  operandb_datasize_i = bs;
      operanda_sof_i = sof; operanda_eof_i = eof;
      operanda_valid_i = 1'b1; operandb_valid_i = 1'b1;
      @(negedge clk_i);
      while (!operanda_ready_o && waited < 200) begin
         @(negedge clk_i);
         waited++;
      end
      if (operanda_ready_o) begin
         check("b_ready_match", operandb_ready_o, nb_mask[cfg_mode_i] & ~cfg_bypass_i);
         acc_cyc = cyc;
         model_beat(a, as, b, bs, sof, eof);
      end else begin
         check("accept_timeout", operanda_ready_o, 1'b1);
      end
      @(posedge clk_i);
      #1;
      operanda_valid_i = 1'b0; operandb_valid_i = 1'b0;
      operanda_sof_i = 1'b0;   operanda_eof_i = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      rand_en = 1'b0;
      man_rdy = 1'b1;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk_i);
         n++;
      end
      check("drain_pending", exp_q.size(), 0);
      repeat (4) @(negedge clk_i);
      check("idle_after_drain", output_valid_o, 1'b0);
      @(posedge clk_i);
      #1;
   endtask

   task automatic cmd_pulse();
      cmd_start_i = 1'b1;
      operanda_valid_i = 1'b1; operandb_valid_i = 1'b1;
      @(negedge clk_i);
      check("ready_during_start", operanda_ready_o, 1'b0);
      @(posedge clk_i);
      #1;
      cmd_start_i = 1'b0;
      operanda_valid_i = 1'b0; operandb_valid_i = 1'b0;
      exp_q.delete();
      model_acc = 0;
      model_sat = 1'b0;
   endtask

   task automatic set_cfg(input logic sgn, input logic [3:0] mode, input logic [5:0] sh,
                          input logic rnd, input logic sat);
      cfg_use_signed_i = sgn; cfg_mode_i = mode; cfg_shift_i = sh;
      cfg_round_i = rnd; cfg_sat_i = sat; cfg_bypass_i = 1'b0;
   endtask

   // Scoreboard / monitor
   always @(negedge clk_i) begin
      logic [33:0] e;
      if (resetn_i) begin
         if (operanda_valid_i && !operanda_ready_o) saw_stall = 1'b1;
         if (operandb_ready_o) check("b_only_with_a", operanda_ready_o, 1'b1);
         if (output_valid_o && output_ready_i) begin
            out_count++;
            last_out_cyc  = cyc;
            last_out_data = output_data_o;
            last_out_size = output_datasize_o;
            if (exp_q.size() == 0) begin
               check("unexpected_out", output_valid_o, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check("out_data", output_data_o, e[31:0]);
               check("out_size", output_datasize_o, e[33:32]);
            end
         end
      end
   end

   initial begin
      int base;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_valid", output_valid_o, 1'b0);
      check("rst_data", output_data_o, 32'd0);
      check("rst_size", output_datasize_o, 2'd0);
      check("rst_sat", status_sat_o, 1'b0);
      check("rst_ready_a", operanda_ready_o, 1'b0);
      check("rst_ready_b", operandb_ready_o, 1'b0);
      @(posedge clk_i);
      #1 resetn_i = 1'b1;
      @(posedge clk_i);
      #1;

      // Signed A*B with 16-bit operands, latency
      set_cfg(1'b1, 4'd0, 6'd0, 1'b0, 1'b0);
      send(32'd3, 2'd1, 32'h0000FFFC, 2'd1, 1'b0, 1'b0);
      drain();
      check("t1_data", last_out_data, 32'hFFFFFFF4);
      check("t1_size", last_out_size, 2'd1);
      check("t1_latency", last_out_cyc - acc_cyc, 3);

      // Accumulate frame and single-beat frame
      set_cfg(1'b0, 4'd2, 6'd0, 1'b0, 1'b0);
      base = out_count;
      send(32'd1, 2'd2, 32'd2, 2'd2, 1'b1, 1'b0);
      send(32'd2, 2'd2, 32'd2, 2'd2, 1'b0, 1'b0);
      send(32'd3, 2'd2, 32'd2, 2'd2, 1'b0, 1'b0);
      send(32'd4, 2'd2, 32'd2, 2'd2, 1'b0, 1'b1);
      drain();
      check("acc_count", out_count - base, 1);
      check("acc_sum", last_out_data, 32'd20);
      send(32'd5, 2'd2, 32'd2, 2'd2, 1'b1, 1'b1);
      drain();
      check("acc_restart", last_out_data, 32'd10);

      // Saturation, truncation, sticky flag cleared by start
      set_cfg(1'b1, 4'd1, 6'd0, 1'b0, 1'b1);
      cfg_reg0_i = 32'd0;
      send(32'h40000000, 2'd2, 32'd4, 2'd2, 1'b0, 1'b0);
      drain();
      check("sat_data", last_out_data, 32'h7FFFFFFF);
      check("sat_flag", status_sat_o, 1'b1);
      cfg_sat_i = 1'b0;
      send(32'h40000000, 2'd2, 32'd4, 2'd2, 1'b0, 1'b0);
      drain();
      check("trunc_data", last_out_data, 32'h00000000);
      check("sat_sticky", status_sat_o, 1'b1);
      cmd_pulse();
      @(negedge clk_i);
      check("sat_cleared", status_sat_o, 1'b0);
      @(posedge clk_i);
      #1;

      // Shift and rounding
      set_cfg(1'b1, 4'd13, 6'd2, 1'b0, 1'b0);
      send(32'd5, 2'd2, 32'd2, 2'd2, 1'b0, 1'b0);
      drain();
      check("shift_trunc", last_out_data, 32'd1);
      cfg_round_i = 1'b1;
      send(32'd5, 2'd2, 32'd2, 2'd2, 1'b0, 1'b0);
      drain();
      check("shift_round", last_out_data, 32'd2);
      set_cfg(1'b0, 4'd13, 6'd1, 1'b0, 1'b0);
      send(32'hFFFFFFFF, 2'd2, 32'd1, 2'd2, 1'b0, 1'b0);
      drain();
      check("shift_logical", last_out_data, 32'h80000000);

      // Backpressure
      set_cfg(1'b0, 4'd0, 6'd0, 1'b0, 1'b0);
      base = out_count;
      saw_stall = 1'b0;
      man_rdy = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++)
               send(32'(i + 1), 2'd2, 32'd3, 2'd2, 1'b0, 1'b0);
         end
         begin
            repeat (5) @(posedge clk_i);
            #1 man_rdy = 1'b1;
         end
      join
      drain();
      check("bp_count", out_count - base, 6);
      check("bp_stall_seen", saw_stall, 1'b1);
      check("bp_last", last_out_data, 32'd18);

      // Mid-frame abort in accumulate mode
      set_cfg(1'b0, 4'd6, 6'd0, 1'b0, 1'b0);
      base = out_count;
      send(32'd2, 2'd2, 32'd0, 2'd2, 1'b1, 1'b0);
      send(32'd4, 2'd2, 32'd0, 2'd2, 1'b0, 1'b0);
      cmd_pulse();
      send(32'd3, 2'd2, 32'd0, 2'd2, 1'b1, 1'b1);
      drain();
      check("abort_count", out_count - base, 1);
      check("abort_next", last_out_data, 32'd9);

      // Randomized blocks
      cmd_pulse();
      for (int blk = 0; blk < 30; blk++) begin
         logic acc_like;
         set_cfg(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 6'($urandom_range(0, 39)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         cfg_bypass_i = ($urandom_range(0, 7) == 0);
         cfg_reg0_i = $urandom;
         cfg_reg1_i = $urandom;
         acc_like = !cfg_bypass_i && (cfg_mode_i == 4'd2 || cfg_mode_i == 4'd6 || cfg_mode_i == 4'd12);
         rand_en = 1'b1;
         for (int k = 0; k < 5; k++) begin
            logic sof, eof;
            sof = acc_like ? (k == 0) : 1'($urandom_range(0, 1));
            eof = acc_like ? (k == 4) : 1'($urandom_range(0, 1));
            send($urandom, 2'($urandom_range(0, 2)), $urandom, 2'($urandom_range(0, 2)), sof, eof);
         end
         drain();
         check("rand_sat_flag", status_sat_o, model_sat);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/udma_filter_au_pipe.md
Name: udma_filter_au_pipe

Overview:
- Parametrised next-generation uDMA filter arithmetic unit: per-beat multiply/add/accumulate on stream A (and optional stream B) with configurable width, accumulator width, rounding and saturation.
- Fully back-pressurable 3-stage pipeline: a stall never drops or duplicates a beat.
- Sits between the filter operand streamers and the output streamer in the uDMA filter datapath.

Parameters:
- DATA_WIDTH, 32, operand and output data width.
- ACC_WIDTH, 40, multiply-accumulate width, with ACC_WIDTH >= DATA_WIDTH+2.
- SHIFT_W, 6, width of cfg_shift_i. The shift range is 0..ACC_WIDTH-1.

Ports:
- clk_i  in  1  clock
- resetn_i  in  1  asynchronous active-low reset
- cfg_use_signed_i  in  1  signed operands and result
- cfg_bypass_i  in  1  result = A, B not consumed
- cfg_mode_i  in  4  mode, encoding per udma_filter_pkg
- cfg_shift_i  in  SHIFT_W  output right shift
- cfg_round_i  in  1  round-half-up before shift
- cfg_sat_i  in  1  saturate the result to DATA_WIDTH
- cfg_reg0_i  in  DATA_WIDTH  addend register
- cfg_reg1_i  in  DATA_WIDTH  multiplier register
- cmd_start_i  in  1  synchronous flush/restart
- operanda_data_i  in  DATA_WIDTH  stream A data
- operanda_datasize_i  in  2  A size: 0=8b, 1=16b, else full width
- operanda_valid_i  in  1  A valid
- operanda_sof_i  in  1  A start of frame
- operanda_eof_i  in  1  A end of frame
- operanda_ready_o  out  1  A ready
- operandb_data_i  in  DATA_WIDTH  stream B data
- operandb_datasize_i  in  2  B size
- operandb_valid_i  in  1  B valid
- operandb_ready_o  out  1  B ready
- output_data_o  out  DATA_WIDTH  result
- output_datasize_o  out  2  datasize of the beat, carried with it through the pipeline
- output_valid_o  out  1  result valid
- output_ready_i  in  1  result ready
- status_sat_o  out  1  sticky saturation flag

Behaviour:
- Reset: all pipeline valid bits, registers, accumulator and status_sat_o go to 0. All outputs read 0.
- Input extension: 8/16-bit inputs are sign-extended when cfg_use_signed_i=1, else zero-extended.
- needB: set by modes 0,1,2,4,5,9,10,13,14 when bypass=0.
- Input handshake:
  - S0 accepts a beat when S0 can advance AND operanda_valid_i AND (!needB OR operandb_valid_i).
  - operanda_ready_o equals that acceptance.
  - operandb_ready_o = acceptance AND needB.
  - A and B always transfer in the same cycle.
- Pipeline stages:
  - S0 registers A, B, sof, eof and datasize.
  - S1 computes prod = A*M + (inv ? -S : S), computed in ACC_WIDTH and wrapping on overflow.
    - M is selected from {B, A, reg1, 1}.
    - S is selected from {B, reg0, acc, 0}, per the mode table (modes 0–15 as in the package).
    - 'X-B' modes subtract.
  - S2 applies shift, round and saturate, then registers the output.
- Stage advance: a stage advances when the next stage is empty or advancing. S2 advances when !output_valid_o OR output_ready_i. Bubbles collapse.
- Latency: beat accepted in cycle N gives output_valid_o at N+3 with no stall.
- Accumulate modes (2, 6, 12):
  - acc <= (sof ? 0 : acc) + A*M.
  - Only the eof beat enters S2. Non-eof beats produce no output.
  - A beat with sof and eof together outputs the product alone.
- Shift:
  - Arithmetic right shift if signed, logical if unsigned.
  - With round=1 and shift>0, add 1<<(shift-1) before shifting.
  - shift=0: rounding has no effect.
- Saturation (sat=1):
  - Clamp to [-2^(DW-1), 2^(DW-1)-1] if signed, [0, 2^DW-1] if unsigned.
  - Any clamp sets status_sat_o (sticky).
  - sat=0: truncate to DATA_WIDTH LSBs.
- Bypass: output = A, then shift/round/saturate still apply.
- cmd_start_i (synchronous, highest priority):
  - Clears all valid bits, acc and status_sat_o.
  - Ready outputs are 0 in that cycle.
  - In-flight beats are discarded.
- Configuration must be stable while beats are in flight. Changing it mid-stream is undefined.

Decomposition:
- udma_filter_pkg holds:
  - mode localparams MODE_AXB..MODE_APREG;
  - a decode struct {en_opb, mul_sel, sum_sel, sum_inv, acc};
  - a decode function mode -> struct.
- One sub-module, udma_filter_shsat: combinational shift/round/saturate, used by S2, producing data and a sat flag.

Test Plan:
- Signed mode 0, 16-bit, A=3, B=-4, shift 0 → output_data_o=0xFFFFFFF4, datasize=1, valid exactly 3 cycles after the handshake.
- Mode 2, frame A={1,2,3,4} (sof on 1, eof on 4), B=2 → exactly one output, 20. A second frame {5} with sof+eof → 10 (acc restarted).
- Signed mode 1, A=0x40000000, B=4, reg0=0:
  - sat=1 → 0x7FFFFFFF and status_sat_o=1;
  - sat=0 → 0x00000000;
  - then cmd_start_i → status_sat_o=0.
- Mode 13, A=5, B=2, shift=2:
  - round=0 → 1;
  - round=1 → 2;
  - unsigned A=0xFFFFFFFF, B=1, shift=1 → 0x80000000 (logical shift, no wrap inside ACC_WIDTH).
- Backpressure: stream 6 beats in mode 0 with output_ready_i low for 5 cycles → ready_o drops once S0–S2 are full, all 6 results emerge in order with no duplicates, and B is never consumed without A.
- Mid-frame cmd_start_i in mode 6 after 2 beats → no output from the aborted frame, and the next frame {3} sof+eof yields 9.
